// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the MIPS instruction fetch unit.
//   fetch_state_t : fetch FSM states (F_REQ, F_WAIT, F_DROP)
//   OP_* / FUNCT_*: bit positions of the opcode and function fields
//   PC_STEP       : PC increment per fetched word
//   INSTR_W       : instruction word width
//   alignPc()     : forces a PC onto a word boundary
// ---------------------------------------------------------------------------
package ifu_pkg;

  localparam int INSTR_W   = 32;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_DROP
  } fetch_state_t;

  // Masking rather than slicing keeps every bit of the incoming PC in use.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small instruction buffer between the memory side and the decoder.
// Each entry holds {pc, instr}; the head entry is presented combinationally.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : write i_pushData at the tail
//   i_pushData    : {pc, instr} entry to store
//   i_pop         : drop the head entry
//   i_flush       : discard all entries (wins over push/pop)
//   o_headData    : head entry {pc, instr}
//   o_count       : number of stored entries
//   o_empty       : no entries stored
// ---------------------------------------------------------------------------
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [2*INSTR_W-1:0]   i_pushData,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [2*INSTR_W-1:0]   o_headData,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_empty
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [2*INSTR_W-1:0] r_mem [BUF_DEPTH];
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_full;
  logic                 w_doPush;
  logic                 w_doPop;

  assign w_full  = (r_count == CNT_W'(BUF_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A push into a full buffer is only accepted when the head leaves in the
  // same cycle; pointers wrap naturally because the depth is a power of two.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!w_full || w_doPop);

  assign o_headData = r_mem[r_rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int k = 0; k < BUF_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// MIPS instruction fetch stage. Holds the PC, fetches words over a
// req/gnt/rvalid memory interface with at most one transaction in flight,
// buffers them in ifu_fifo and hands them to the decoder with valid/ready.
// A redirect flushes the buffer and restarts fetching at the new PC; a
// response still in flight at that moment is dropped in F_DROP.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_cnt output,
// counting instructions accepted by the decoder.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   imem_req/addr        : fetch request and word address
//   imem_gnt             : request accepted
//   imem_rvalid/rdata    : returned instruction word
//   instr_valid/ready    : decoder handshake
//   instr, instr_pc      : head instruction and its PC
//   OP, funct            : pre-split opcode and function fields
//   fetch_cnt            : delivered instruction count (macro only)
//   redirect/redirect_pc : branch/jump taken and its target
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  OP,
  output logic [5:0]  funct,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
`endif
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t         r_state;
  fetch_state_t         w_nextState;
  logic [31:0]          r_pc;
  logic [31:0]          r_reqAddr;
  logic                 r_started;
  logic                 w_grant;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [CNT_W-1:0]     w_freeSlots;
  logic [2*INSTR_W-1:0] w_head;

  // A request is only raised when its response is guaranteed a slot, so the
  // buffer never overflows and rvalid needs no back-pressure. r_started holds
  // the request low for the first cycle after reset release.
  assign w_freeSlots = CNT_W'(BUF_DEPTH) - w_count;
  assign w_grant     = imem_req && imem_gnt;
  assign imem_addr   = r_pc;

  always_comb begin
    w_nextState = r_state;
    imem_req    = 1'b0;
    case (r_state)
      F_REQ: begin
        imem_req = r_started && (w_freeSlots != '0);
        if (redirect) begin
          w_nextState = (imem_req && imem_gnt) ? F_DROP : F_REQ;
        end else if (imem_req && imem_gnt) begin
          w_nextState = F_WAIT;
        end
      end
      F_WAIT: begin
        if (redirect) begin
          w_nextState = imem_rvalid ? F_REQ : F_DROP;
        end else if (imem_rvalid) begin
          w_nextState = F_REQ;
        end
      end
      F_DROP: begin
        // Stay here until the stale response arrives, even across further
        // redirects, so only one transaction is ever outstanding.
        if (imem_rvalid) begin
          w_nextState = F_REQ;
        end
      end
      default: w_nextState = F_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= F_REQ;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_started <= 1'b1;
    end
  end

  // The granted address is remembered so the returned word is tagged with
  // its own PC while r_pc has already moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_reqAddr <= '0;
    end else begin
      if (w_grant) begin
        r_reqAddr <= r_pc;
      end
      if (redirect) begin
        r_pc <= alignPc(redirect_pc);
      end else if (w_grant) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  // Redirect discards the coincident response and ignores the coincident pop.
  assign w_push = (r_state == F_WAIT) && imem_rvalid && !redirect;
  assign w_pop  = instr_valid && instr_ready && !redirect;

  ifu_fifo #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pushData ({r_reqAddr, imem_rdata}),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .o_headData (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty)
  );

  assign instr_valid = !w_empty;
  assign instr_pc    = w_head[2*INSTR_W-1:INSTR_W];
  assign instr       = w_head[INSTR_W-1:0];
  assign OP          = instr[OP_MSB:OP_LSB];
  assign funct       = instr[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetchCnt;

  // Counts decoder pops only; a redirect leaves the running total alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchCnt <= '0;
    end else if (w_pop) begin
      r_fetchCnt <= r_fetchCnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetchCnt;
`endif

endmodule
